// File: rtl/ptmch_trg_gen.sv
// Five-channel trigger pulse generator driven by SPI command strobes.
// Each channel runs PULSE/GAP timing with a one-deep pending FIRE slot.
module ptmch_trg_gen #(
  parameter int PLS_WIDTH = 16,
  parameter int PLS_GAP   = 8
) (
  input  logic       CLK160M,
  input  logic       RESET,
  input  logic       CMD_VLD,
  input  logic [7:0] CMD_INST,
  input  logic [7:0] CMD_ADDR,
  output logic [4:0] TRG_PLS,
  output logic       STS_VLD,
  output logic [7:0] STS_DATA
);

  localparam logic [7:0] W_LAST = 8'(PLS_WIDTH - 1);
  localparam logic [7:0] G_LAST = 8'(PLS_GAP - 1);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } st_t;

  logic [4:0] sel;
  logic [4:0] fire;
  logic [4:0] busy;
  logic [4:0] drop;
  logic       rd;
  logic       abort;
  logic [2:0] ovf;

  always_comb begin
    sel = '0;
    case (CMD_ADDR[7:4])
      4'hA:    sel = 5'b00001;
      4'hB:    sel = 5'b00010;
      4'hC:    sel = 5'b00100;
      4'hD:    sel = 5'b01000;
      4'hE:    sel = 5'b10000;
      default: sel = '0;
    endcase
    fire  = (CMD_VLD && CMD_INST == 8'h0F) ? sel : '0;
    rd    = CMD_VLD && CMD_INST == 8'h05;
    abort = CMD_VLD && CMD_INST == 8'h06;
  end

  for (genvar g = 0; g < 5; g++) begin : g_ch
    st_t        st;
    logic [7:0] cnt;
    logic       pend;
    logic       trg;

    assign TRG_PLS[g] = trg;
    assign busy[g]    = (st != IDLE) || pend;
    // A FIRE arriving while a slot is already queued is always lost.
    assign drop[g]    = fire[g] && pend;

    always_ff @(posedge CLK160M or posedge RESET) begin
      if (RESET) begin
        st   <= IDLE;
        cnt  <= '0;
        pend <= 1'b0;
        trg  <= 1'b0;
      end else if (abort) begin
        st   <= IDLE;
        cnt  <= '0;
        pend <= 1'b0;
        trg  <= 1'b0;
      end else begin
        case (st)
          IDLE: begin
            if (fire[g]) begin
              st  <= PULSE;
              cnt <= W_LAST;
              trg <= 1'b1;
            end
          end
          PULSE: begin
            if (fire[g] && !pend) pend <= 1'b1;
            if (cnt == 8'd0) begin
              st  <= GAP;
              cnt <= G_LAST;
              trg <= 1'b0;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
          GAP: begin
            if (cnt == 8'd0) begin
              if (pend || fire[g]) begin
                st   <= PULSE;
                cnt  <= W_LAST;
                pend <= 1'b0;
                trg  <= 1'b1;
              end else begin
                st <= IDLE;
              end
            end else begin
              cnt <= cnt - 8'd1;
              if (fire[g] && !pend) pend <= 1'b1;
            end
          end
          default: begin
            st  <= IDLE;
            trg <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK160M or posedge RESET) begin
    if (RESET) begin
      STS_VLD  <= 1'b0;
      STS_DATA <= '0;
      ovf      <= '0;
    end else begin
      STS_VLD <= rd;
      if (rd) begin
        STS_DATA <= {ovf, busy};
        ovf      <= (|drop) ? 3'd1 : 3'd0;
      end else if ((|drop) && ovf != 3'd7) begin
        ovf <= ovf + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_ptmch_trg_gen.sv
// Bench for ptmch_trg_gen: directed timing scenarios plus random
// command traffic against a pulse-window reference model.
module tb_ptmch_trg_gen;

  localparam int W = 16;
  localparam int G = 8;

  logic       clk;
  logic       rst;
  logic       cmd_vld;
  logic [7:0] cmd_inst;
  logic [7:0] cmd_addr;
  logic [4:0] trg_pls;
  logic       sts_vld;
  logic [7:0] sts_data;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  int   now;
  int   m_start[5];
  bit   m_act[5];
  bit   m_pend[5];
  int   m_ovf;
  bit   m_sv;
  logic [7:0] m_sd;

  ptmch_trg_gen #(.PLS_WIDTH(W), .PLS_GAP(G)) dut (
    .CLK160M (clk),
    .RESET   (rst),
    .CMD_VLD (cmd_vld),
    .CMD_INST(cmd_inst),
    .CMD_ADDR(cmd_addr),
    .TRG_PLS (trg_pls),
    .STS_VLD (sts_vld),
    .STS_DATA(sts_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit m_live(int ch, int n);
    return m_act[ch] && (n - m_start[ch]) < W + G;
  endfunction

  function automatic logic [4:0] exp_trg();
    logic [4:0] v = '0;
    for (int ch = 0; ch < 5; ch++)
      v[ch] = m_act[ch] && (now - m_start[ch]) < W;
    return v;
  endfunction

  task automatic m_reset();
    for (int ch = 0; ch < 5; ch++) begin
      m_act[ch] = 0; m_pend[ch] = 0; m_start[ch] = 0;
    end
    m_ovf = 0; m_sv = 0; m_sd = '0; now = 0;
  endtask

  task automatic m_step(input bit v, input logic [7:0] inst,
                        input logic [7:0] addr);
    bit   drop = 0;
    int   sel  = -1;
    logic [4:0] busy = '0;
    if (addr[7:4] >= 4'hA && addr[7:4] <= 4'hE) sel = int'(addr[7:4]) - 10;
    for (int ch = 0; ch < 5; ch++)
      busy[ch] = m_live(ch, now) || m_pend[ch];
    m_sv = v && inst == 8'h05;
    for (int ch = 0; ch < 5; ch++) begin
      bit f    = v && inst == 8'h0F && sel == ch;
      bit live = m_live(ch, now);
      bit last = live && (now - m_start[ch]) == W + G - 1;
      if (f && m_pend[ch]) drop = 1;
      if (last && (m_pend[ch] || f)) begin
        m_start[ch] = now + 1; m_pend[ch] = 0;
      end else if (f && !live) begin
        m_act[ch] = 1; m_start[ch] = now + 1;
      end else if (f && !m_pend[ch]) begin
        m_pend[ch] = 1;
      end
    end
    if (m_sv) begin
      m_sd  = {3'(m_ovf), busy};
      m_ovf = drop ? 1 : 0;
    end else if (drop && m_ovf < 7) begin
      m_ovf++;
    end
    if (v && inst == 8'h06)
      for (int ch = 0; ch < 5; ch++) begin
        m_act[ch] = 0; m_pend[ch] = 0;
      end
  endtask

  task automatic tick(input bit v, input logic [7:0] inst,
                      input logic [7:0] addr);
    cmd_vld = v; cmd_inst = inst; cmd_addr = addr;
    m_step(v, inst, addr);
    @(posedge clk); #1;
    now++;
    cmd_vld = 0; cmd_inst = '0; cmd_addr = '0;
  endtask

  task automatic do_reset();
    cmd_vld = 0; cmd_inst = '0; cmd_addr = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_vld = 1; cmd_inst = 8'h0F; cmd_addr = 8'hA0;
    repeat (3) @(posedge clk);
    #1;
    tot_cnt++;
    if ({trg_pls, sts_vld, sts_data} !== 14'd0)
      $display("FAIL reset_outputs trg=%b vld=%b data=%h want 0",
               trg_pls, sts_vld, sts_data);
    else pass_cnt++;
    cmd_vld = 0;
    rst = 1'b0;
    m_reset();
    for (int i = 0; i < 5; i++) begin
      tick(0, 8'h00, 8'h00);
      tot_cnt++;
      if (trg_pls !== 5'd0)
        $display("FAIL reset_cmd_ignored trg=%b want 0", trg_pls);
      else pass_cnt++;
    end
  endtask

  task automatic test_single();
    do_reset();
    while (now <= 40) begin
      logic [4:0] e;
      if (now == 10)      tick(1, 8'h0F, 8'hA0);
      else if (now == 34) tick(1, 8'h05, 8'h00);
      else if (now == 36) tick(1, 8'h05, 8'h00);
      else                tick(0, 8'h00, 8'h00);
      e = (now >= 11 && now <= 26) ? 5'b00001 : 5'b00000;
      tot_cnt++;
      if (trg_pls !== e)
        $display("FAIL single_pulse cyc=%0d trg=%b want %b", now, trg_pls, e);
      else pass_cnt++;
      if (now == 35 || now == 37) begin
        e = (now == 35) ? 5'h01 : 5'h00;
        tot_cnt++;
        if (sts_vld !== 1'b1 || sts_data !== {3'd0, e})
          $display("FAIL single_busy cyc=%0d vld=%b data=%h want 1/%h",
                   now, sts_vld, sts_data, e);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_pend_ovf();
    do_reset();
    while (now <= 72) begin
      logic [4:0] e;
      if (now == 10 || now == 15 || now == 16) tick(1, 8'h0F, 8'hB3);
      else if (now == 60 || now == 70)         tick(1, 8'h05, 8'h00);
      else                                     tick(0, 8'h00, 8'h00);
      e = ((now >= 11 && now <= 26) || (now >= 35 && now <= 50)) ?
          5'b00010 : 5'b00000;
      tot_cnt++;
      if (trg_pls !== e)
        $display("FAIL pend_pulse cyc=%0d trg=%b want %b", now, trg_pls, e);
      else pass_cnt++;
      if (now == 61 || now == 62 || now == 71) begin
        tot_cnt++;
        if (sts_vld !== (now != 62) ||
            sts_data !== ((now == 71) ? 8'h00 : 8'h20))
          $display("FAIL pend_status cyc=%0d vld=%b data=%h", now,
                   sts_vld, sts_data);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_last_gap();
    do_reset();
    while (now <= 55) begin
      logic [4:0] e;
      if (now == 10 || now == 34) tick(1, 8'h0F, 8'hC0);
      else if (now == 12)         tick(1, 8'h05, 8'h00);
      else                        tick(0, 8'h00, 8'h00);
      e = ((now >= 11 && now <= 26) || (now >= 35 && now <= 50)) ?
          5'b00100 : 5'b00000;
      tot_cnt++;
      if (trg_pls !== e)
        $display("FAIL last_gap cyc=%0d trg=%b want %b", now, trg_pls, e);
      else pass_cnt++;
      if (now == 13) begin
        tot_cnt++;
        if (sts_vld !== 1'b1 || sts_data !== 8'h04)
          $display("FAIL last_gap_sts vld=%b data=%h want 1/04",
                   sts_vld, sts_data);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_all_channels();
    do_reset();
    while (now <= 60) begin
      logic [4:0] e = '0;
      if (now >= 10 && now <= 14)
        tick(1, 8'h0F, {4'(now), 4'h0});
      else if (now == 15) tick(1, 8'h0F, 8'hF0);
      else if (now == 16) tick(1, 8'h03, 8'hA0);
      else                tick(0, 8'h00, 8'h00);
      for (int k = 0; k < 5; k++)
        e[k] = (now >= 11 + k && now <= 26 + k);
      tot_cnt++;
      if (trg_pls !== e)
        $display("FAIL all_channels cyc=%0d trg=%b want %b", now, trg_pls, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_abort();
    do_reset();
    while (now <= 40) begin
      logic [4:0] e;
      if (now == 10 || now == 20) tick(1, 8'h0F, 8'hA0);
      else if (now == 14)         tick(1, 8'h06, 8'h00);
      else if (now == 16)         tick(1, 8'h05, 8'h00);
      else                        tick(0, 8'h00, 8'h00);
      e = ((now >= 11 && now <= 14) || (now >= 21 && now <= 36)) ?
          5'b00001 : 5'b00000;
      tot_cnt++;
      if (trg_pls !== e)
        $display("FAIL abort cyc=%0d trg=%b want %b", now, trg_pls, e);
      else pass_cnt++;
      if (now == 17) begin
        tot_cnt++;
        if (sts_vld !== 1'b1 || sts_data !== 8'h00)
          $display("FAIL abort_busy vld=%b data=%h want 1/00",
                   sts_vld, sts_data);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_async_reset();
    int hi = 0;
    do_reset();
    while (now < 15) begin
      if (now == 10) tick(1, 8'h0F, 8'hE0);
      else           tick(0, 8'h00, 8'h00);
    end
    tot_cnt++;
    if (trg_pls !== 5'b10000)
      $display("FAIL async_pre trg=%b want 10000", trg_pls);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    tot_cnt++;
    if (trg_pls !== 5'd0)
      $display("FAIL async_reset trg=%b want 00000", trg_pls);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
    tick(0, 8'h00, 8'h00);
    tick(1, 8'h0F, 8'hE0);
    for (int i = 0; i < 30; i++) begin
      if (trg_pls[4]) hi++;
      tick(0, 8'h00, 8'h00);
    end
    tot_cnt++;
    if (hi != W)
      $display("FAIL async_refire high_cycles=%0d want %0d", hi, W);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 99);
      logic [7:0] inst;
      logic [7:0] addr;
      addr = {4'($urandom_range(9, 15)), 4'($urandom)};
      if (r < 30)      inst = 8'h0F;
      else if (r < 34) inst = 8'h05;
      else if (r < 35) inst = 8'h06;
      else             inst = 8'($urandom);
      tick(r < 45, inst, addr);
      tot_cnt++;
      if (trg_pls !== exp_trg() || sts_vld !== m_sv || sts_data !== m_sd) begin
        if (errs < 10)
          $display("FAIL random cyc=%0d trg=%b/%b vld=%b/%b data=%h/%h",
                   now, trg_pls, exp_trg(), sts_vld, m_sv, sts_data, m_sd);
        errs++;
      end else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_vld = 0; cmd_inst = '0; cmd_addr = '0;
    m_reset();
    test_reset();
    test_single();
    test_pend_ovf();
    test_last_gap();
    test_all_channels();
    test_abort();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
